// File: rtl/cache_fm_req_q.sv
// Far-memory request queue: in-order FIFO of miss fills and dirty evictions from
// lookup stage q3, issued to FM with a cap on reads in flight and a tagged read-return path.
module cache_fm_req_q #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_OUT_RD = 4,
  parameter int unsigned PIPE_SLACK = 2,
  parameter int unsigned CL_ADDR_W  = 28,
  parameter int unsigned CL_W       = 128,
  parameter int unsigned TQ_ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_fm_req_valid,
  input  logic                 pipe_fm_req_op,
  input  logic [CL_ADDR_W-1:0] pipe_fm_req_cl_address,
  input  logic [CL_W-1:0]      pipe_fm_req_data,
  input  logic [TQ_ID_W-1:0]   pipe_fm_req_tq_id,
  output logic                 fm_q_stall,
  output logic                 fm_req_valid,
  input  logic                 fm_req_ready,
  output logic                 fm_req_op,
  output logic [CL_ADDR_W-1:0] fm_req_cl_address,
  output logic [CL_W-1:0]      fm_req_data,
  output logic [TQ_ID_W-1:0]   fm_req_tq_id,
  input  logic                 fm_rd_rsp_valid,
  input  logic [TQ_ID_W-1:0]   fm_rd_rsp_tq_id,
  input  logic [CL_W-1:0]      fm_rd_rsp_data,
  output logic                 fm2cache_rd_rsp_valid,
  output logic [TQ_ID_W-1:0]   fm2cache_rd_rsp_tq_id,
  output logic [CL_W-1:0]      fm2cache_rd_rsp_data,
  output logic                 overflow_err,
  output logic                 unexpected_rsp_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT_RD + 1);

  logic                 mem_op_q   [DEPTH];
  logic [CL_ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [CL_W-1:0]      mem_data_q [DEPTH];
  logic [TQ_ID_W-1:0]   mem_tq_q   [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               stall_q, stall_d;
  logic               overflow_q, overflow_d;
  logic               unexp_q, unexp_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [TQ_ID_W-1:0] rsp_tq_q, rsp_tq_d;
  logic [CL_W-1:0]    rsp_data_q, rsp_data_d;

  logic not_empty, head_rd, pop, push, rd_pop, rsp_ok;

  // Queue control, read-credit tracking and response capture
  always_comb begin
    not_empty   = (count_q != '0);
    head_rd     = not_empty && !mem_op_q[rd_ptr_q];
    // A read head stalled on credits also holds back everything queued behind it
    fm_req_valid = not_empty && !(head_rd && (out_q == OUT_W'(MAX_OUT_RD)));
    pop         = fm_req_valid && fm_req_ready;
    push        = pipe_fm_req_valid && ((count_q < CNT_W'(DEPTH)) || pop);
    rd_pop      = pop && head_rd;
    rsp_ok      = fm_rd_rsp_valid && (out_q != '0);

    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    out_d = out_q;
    unique case ({rd_pop, rsp_ok})
      2'b10:   out_d = out_q + OUT_W'(1);
      2'b01:   out_d = out_q - OUT_W'(1);
      default: out_d = out_q;
    endcase

    stall_d     = (count_d >= CNT_W'(DEPTH - PIPE_SLACK));
    overflow_d  = overflow_q || (pipe_fm_req_valid && !push);
    unexp_d     = unexp_q || (fm_rd_rsp_valid && (out_q == '0));
    rsp_valid_d = rsp_ok;
    rsp_tq_d    = rsp_ok ? fm_rd_rsp_tq_id : '0;
    rsp_data_d  = rsp_ok ? fm_rd_rsp_data  : '0;

    fm_req_op         = not_empty ? mem_op_q[rd_ptr_q]   : 1'b0;
    fm_req_cl_address = not_empty ? mem_addr_q[rd_ptr_q] : '0;
    fm_req_data       = not_empty ? mem_data_q[rd_ptr_q] : '0;
    fm_req_tq_id      = not_empty ? mem_tq_q[rd_ptr_q]   : '0;
  end

  // Entry storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op_q[wr_ptr_q]   <= pipe_fm_req_op;
      mem_addr_q[wr_ptr_q] <= pipe_fm_req_cl_address;
      mem_data_q[wr_ptr_q] <= pipe_fm_req_data;
      mem_tq_q[wr_ptr_q]   <= pipe_fm_req_tq_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      stall_q     <= 1'b0;
      overflow_q  <= 1'b0;
      unexp_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tq_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      stall_q     <= stall_d;
      overflow_q  <= overflow_d;
      unexp_q     <= unexp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tq_q    <= rsp_tq_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign fm_q_stall            = stall_q;
  assign overflow_err          = overflow_q;
  assign unexpected_rsp_err    = unexp_q;
  assign fm2cache_rd_rsp_valid = rsp_valid_q;
  assign fm2cache_rd_rsp_tq_id = rsp_tq_q;
  assign fm2cache_rd_rsp_data  = rsp_data_q;

endmodule
